program_counter: RTL and testbench
==================================

Name: program_counter

Overview:
- Program-counter register for the five-stage pipeline; holds the address of the instruction being fetched.
- Loads a new value (next PC from the fetch/branch logic) when `write_enable` is high.
- Holds its value when `write_enable` is low, i.e. on a stall.
- Asynchronous active-low reset forces the reset vector.

Parameters:
- WIDTH, 32, bit width of the PC value (`in` and `out`).
- RESET_VALUE, 0, value forced onto `out` while reset is asserted; WIDTH bits wide.

Ports:
- clk  input  1  system clock; all updates on the rising edge.
- rst  input  1  asynchronous active-low reset.
- write_enable  input  1  load enable; 1 = load `in` at the next rising clk edge.
- in  input  WIDTH  next PC value.
- out  output  WIDTH  current PC value, driven directly from the register.
- Positional port order is fixed: write_enable, clk, rst, in, out. Existing instantiations connect by position.

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (rst); these are fixed.
- Reset:
  - rst = 0 forces `out` = RESET_VALUE immediately, without waiting for a clock edge.
  - `out` stays at RESET_VALUE for as long as rst = 0.
  - Reset dominates: write_enable and `in` are ignored while rst = 0, including write_enable = 1.
- Load: on a rising clk edge with rst = 1 and write_enable = 1, `out` <= `in`.
  - Latency is one edge; the new value is visible right after that edge.
- Hold: on a rising clk edge with rst = 1 and write_enable = 0, `out` keeps its previous value.
- Reset release: deasserting rst does not change `out`. The first load happens at the first rising edge where rst = 1 and write_enable = 1.
- Reset mid-operation: asserting rst at any time, including between edges, drops `out` to RESET_VALUE at once. No previously presented `in` is retained.
- Width rules:
  - `in` and `out` are both exactly WIDTH bits.
  - No arithmetic, increment, alignment or sign handling; the value is stored bit-exact.
  - All 2^WIDTH values are legal, including all-ones and 0.
- Output is a pure register output; no combinational path from `in` or write_enable to `out`.
- X on write_enable while rst = 1 is outside the supported operating range. The implementation need not define behaviour there.

Optional Feature:
- Macro: PC_TRACE_EN.
- Defined:
  - On every rising clk edge where `out` changes, the block prints the simulation time and the old and new PC values (decimal and hex).
  - On entry into reset it prints one line stating "reset".
  - Simulation-only code; no effect on synthesized logic or port list.
- Undefined: no trace code compiled; behaviour is otherwise identical.

Test Plan:
- rst = 0, write_enable = 0, in = 1234, run 10 time units -> `out` = 0.
- rst = 0, write_enable = 1, in = 1234, run several clk edges -> `out` stays 0 (reset dominates the write).
- rst = 1, write_enable = 1, in = 1234, one rising edge -> `out` = 1234.
- rst = 1, write_enable = 1, in = 99999999, then in = 12349876 on the following edge -> `out` = 99999999, then 12349876.
- Hold and async reset:
  - Load 12349876, then write_enable = 0, in = 5555, two edges -> `out` still 12349876.
  - Then drive rst = 0 mid-cycle, between edges -> `out` = 0 immediately.
- Boundaries:
  - Load 32'hFFFFFFFF -> `out` = 32'hFFFFFFFF.
  - Load 0 -> `out` = 0.
  - Override RESET_VALUE = 32'h100, assert rst -> `out` = 32'h100.

Source files
------------

// File: rtl/program_counter.sv
// Purpose: program-counter register for the five-stage pipeline; holds the fetch address.
// Latency: one rising clk edge from write_enable=1 to the new value on out; reset is immediate.
// Backpressure: write_enable=0 is a stall and holds out; optional trace via `define PC_TRACE_EN.
module program_counter #(
   parameter int               WIDTH       = 32,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             write_enable,
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in,
   output logic [WIDTH-1:0] out
);

   logic [WIDTH-1:0] pc_d;
   logic [WIDTH-1:0] pc_q;

   // Next-PC select: take the presented value on a load, otherwise hold (stall).
   always_comb begin
      pc_d = pc_q;
      if (write_enable) begin
         pc_d = in;
      end
   end

   // PC register; reset is asynchronous and dominates any load.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q <= RESET_VALUE;
      end else begin
         pc_q <= pc_d;
      end
   end

   // Output comes straight from the flop, so there is no path from in/write_enable to out.
   assign out = pc_q;

`ifdef PC_TRACE_EN
   // Simulation-only trace of every PC change, reported with old and new values.
   always @(posedge clk) begin
      if (rst && (pc_d != pc_q)) begin
         $display("%0t program_counter: pc %0d (0x%h) -> %0d (0x%h)",
                  $time, pc_q, pc_q, pc_d, pc_d);
      end
   end

   // Simulation-only note on each entry into reset.
   always @(negedge rst) begin
      $display("%0t program_counter: reset", $time);
   end
`endif

endmodule

// File: tb/tb_program_counter.sv
// Purpose: randomized + directed self-checking bench for program_counter.
// Latency: expects loads one edge after presentation, reset immediately on assertion.
// Backpressure: write_enable=0 cycles are checked as holds.
module tb_program_counter;

   localparam logic [31:0] RV1 = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst;
   logic        write_enable;
   logic [31:0] in;
   logic [31:0] out0;
   logic [31:0] out1;

   // Expected PC per instance: the last value loaded while out of reset,
   // or that instance's reset vector since the most recent reset assertion.
   logic [31:0] exp0 = 32'h0;
   logic [31:0] exp1 = RV1;

   int checks   = 0;
   int failures = 0;

   program_counter #(.WIDTH(32)) dut0 (
      .write_enable(write_enable),
      .clk         (clk),
      .rst         (rst),
      .in          (in),
      .out         (out0)
   );

   program_counter #(.WIDTH(32), .RESET_VALUE(RV1)) dut1 (
      .write_enable(write_enable),
      .clk         (clk),
      .rst         (rst),
      .in          (in),
      .out         (out1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%h required=0x%h at %0t", name, act, req, $time);
      end
   endtask

   // Every cycle, away from the active edge, both instances must match the model.
   always @(negedge clk) begin
      chk("cycle_out0", out0, exp0);
      chk("cycle_out1", out1, exp1);
   end

   // Present one cycle of inputs shortly after a falling edge and advance the
   // model at the following rising edge.
   task automatic drive(input logic r, input logic we, input logic [31:0] d);
      @(negedge clk);
      #1;
      rst          = r;
      write_enable = we;
      in           = d;
      if (!r) begin
         exp0 = 32'h0;
         exp1 = RV1;
      end
      @(posedge clk);
      #1;
      if (r && we) begin
         exp0 = d;
         exp1 = d;
      end
   endtask

   // Assert reset between edges and check both outputs drop right away.
   task automatic mid_reset(input string name, input logic release_after);
      #1;
      rst  = 1'b0;
      exp0 = 32'h0;
      exp1 = RV1;
      #1;
      chk({name, "_out0"}, out0, 32'h0);
      chk({name, "_out1"}, out1, RV1);
      if (release_after) begin
         #1;
         rst = 1'b1;
      end
   endtask

   initial begin
      logic        r;
      logic        we;
      logic [31:0] d;

      rst          = 1'b0;
      write_enable = 1'b0;
      in           = 32'd1234;
      #10;
      chk("reset_out0", out0, 32'h0);
      chk("reset_out1", out1, RV1);

      // Reset dominates a requested write.
      repeat (3) drive(1'b0, 1'b1, 32'd1234);
      chk("reset_dom_out0", out0, 32'h0);
      chk("reset_dom_out1", out1, RV1);

      drive(1'b1, 1'b1, 32'd1234);
      chk("load_1234", out0, 32'd1234);
      drive(1'b1, 1'b1, 32'd99999999);
      chk("load_99999999", out0, 32'd99999999);
      drive(1'b1, 1'b1, 32'd12349876);
      chk("load_12349876", out0, 32'd12349876);

      // Stall: write_enable low must hold the PC.
      repeat (2) drive(1'b1, 1'b0, 32'd5555);
      chk("hold_out0", out0, 32'd12349876);
      chk("hold_out1", out1, 32'd12349876);

      // Reset asserted between edges, held through the next edge.
      mid_reset("async_reset", 1'b0);
      drive(1'b0, 1'b1, 32'd7777);
      chk("reset_held_out1", out1, RV1);

      drive(1'b1, 1'b1, 32'hFFFF_FFFF);
      chk("load_all_ones", out0, 32'hFFFF_FFFF);
      drive(1'b1, 1'b1, 32'h0);
      chk("load_zero_out0", out0, 32'h0);
      chk("load_zero_out1", out1, 32'h0);

      // Randomized operation with occasional synchronous-looking and mid-cycle resets.
      for (int i = 0; i < 400; i++) begin
         r  = ($urandom_range(0, 19) != 0);
         we = $urandom_range(0, 1) == 1;
         case ($urandom_range(0, 3))
            0:       d = 32'h0;
            1:       d = 32'hFFFF_FFFF;
            default: d = $urandom;
         endcase
         drive(r, we, d);
         if ($urandom_range(0, 29) == 0) begin
            mid_reset("rand_async_reset", 1'b1);
         end
      end

      @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
